// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and sizing for the multiply/divide sequencer
package muldiv_pkg;
  localparam int WIDTH = 32;
  localparam int ITERATIONS = WIDTH;
  localparam int CNT_W = $clog2(ITERATIONS);
  typedef enum logic [1:0] {MULT, MULTU, DIV, DIVU} muldiv_op_e;
  typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} muldiv_state_e;
endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one radix-2 shift-add (multiply) or restoring-subtract (divide) iteration
module muldiv_step
  import muldiv_pkg::*;
(
  input  logic                 is_div,
  input  logic [2*WIDTH-1:0]   acc,
  input  logic [WIDTH-1:0]     opnd,
  output logic [2*WIDTH-1:0]   acc_nx
);
  logic [WIDTH:0] sum;
  logic [WIDTH:0] rem;
  logic [WIDTH:0] diff;
  // multiply: acc = {partial product, remaining multiplier bits}; divide: acc = {remainder, dividend/quotient}
  always_comb begin
    sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    rem = acc[2*WIDTH-1:WIDTH-1];
    diff = rem - {1'b0, opnd};
    acc_nx = is_div ? {diff[WIDTH] ? rem[WIDTH-1:0] : diff[WIDTH-1:0], acc[WIDTH-2:0], ~diff[WIDTH]}
                    : {sum, acc[WIDTH-1:1]};
  end
endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: multi-cycle MULT/MULTU/DIV/DIVU sequencer owning the HI/LO pair
module muldiv_seq
  import muldiv_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hilo_rd,
  input  logic             hilo_wr,
  input  logic             wr_sel,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic             div_zero
);
  muldiv_state_e      state, state_nx;
  muldiv_op_e         op_q;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc, acc_nx, prod;
  logic [WIDTH-1:0]   opnd, a_abs, b_abs, quo, rem, res_hi, res_lo;
  logic               neg_q, neg_r, dz, accept, in_div, in_signed, dbz, div_q;
  // operand conditioning and result sign fix-up
  always_comb begin
    in_div = op[1];
    in_signed = ~op[0];
    dbz = in_div && b == '0;
    accept = start && (state == IDLE || state == DONE);
    a_abs = (in_signed && a[WIDTH-1]) ? -a : a;
    b_abs = (in_signed && b[WIDTH-1]) ? -b : b;
    div_q = op_q == DIV || op_q == DIVU;
    prod = neg_q ? -acc : acc;
    quo = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    res_hi = div_q ? rem : prod[2*WIDTH-1:WIDTH];
    res_lo = div_q ? quo : prod[WIDTH-1:0];
    busy = state == CALC || state == FIXUP;
    stall = (start || hilo_rd || hilo_wr) && busy;
    done = state == DONE;
    div_zero = done && dz;
  end
  muldiv_step u_step (
    .is_div (div_q),
    .acc    (acc),
    .opnd   (opnd),
    .acc_nx (acc_nx)
  );
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  // next state: a new op may start from IDLE or straight out of DONE
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE, DONE: state_nx = accept ? (dbz ? DONE : CALC) : IDLE;
      CALC:       state_nx = cnt == CNT_W'(ITERATIONS - 1) ? FIXUP : CALC;
      FIXUP:      state_nx = DONE;
    endcase
  end
  // operand latch, iteration datapath and counter
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      op_q <= MULT;
      opnd <= '0;
      acc <= '0;
      cnt <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      dz <= 1'b0;
    end else if (accept) begin
      op_q <= muldiv_op_e'(op);
      opnd <= in_div ? b_abs : a_abs;
      acc <= {{WIDTH{1'b0}}, in_div ? a_abs : b_abs};
      cnt <= '0;
      neg_q <= in_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
      neg_r <= in_signed && a[WIDTH-1];
      dz <= dbz;
    end else if (state == CALC) begin
      acc <= acc_nx;
      cnt <= cnt + CNT_W'(1);
    end
  // HI/LO: result at FIXUP, core writes only while idle (a stalled write is re-presented)
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      hi <= '0;
      lo <= '0;
    end else if (state == FIXUP) begin
      hi <= res_hi;
      lo <= res_lo;
    end else if (hilo_wr && !busy) begin
      if (wr_sel) hi <= wr_data;
      else lo <= wr_data;
    end
endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: scoreboard bench for the multiply/divide sequencer
module tb_muldiv_seq;
  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } exp_t;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [31:0] a = '0, b = '0;
  logic        hilo_rd = 1'b0, hilo_wr = 1'b0, wr_sel = 1'b0;
  logic [31:0] wr_data = '0;
  logic [31:0] hi, lo;
  logic        busy, stall, done, div_zero;
  int          checks = 0, failures = 0;
  logic [31:0] mhi = '0, mlo = '0;
  exp_t        sb[$];
  muldiv_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .hilo_rd(hilo_rd), .hilo_wr(hilo_wr), .wr_sel(wr_sel), .wr_data(wr_data),
    .hi(hi), .lo(lo), .busy(busy), .stall(stall), .done(done), .div_zero(div_zero)
  );
  always #5 clk = ~clk;
  function automatic exp_t model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    exp_t e;
    logic [63:0] p;
    e.hi = mhi;
    e.lo = mlo;
    e.dz = 1'b0;
    if (o == 2'd0) begin
      p = {{32{x[31]}}, x} * {{32{y[31]}}, y};
      e.hi = p[63:32];
      e.lo = p[31:0];
    end else if (o == 2'd1) begin
      p = {32'd0, x} * {32'd0, y};
      e.hi = p[63:32];
      e.lo = p[31:0];
    end else if (y == 32'd0) begin
      e.dz = 1'b1;
    end else if (o == 2'd2 && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
      e.lo = x;
      e.hi = 32'd0;
    end else if (o == 2'd2) begin
      e.lo = $signed(x) / $signed(y);
      e.hi = $signed(x) % $signed(y);
    end else begin
      e.lo = x / y;
      e.hi = x % y;
    end
    return e;
  endfunction
  task automatic push_exp(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    exp_t e;
    e = model(o, x, y);
    sb.push_back(e);
    mhi = e.hi;
    mlo = e.lo;
  endtask
  task automatic start_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    op = o;
    a = x;
    b = y;
    start = 1'b1;
    push_exp(o, x, y);
    @(posedge clk);
    #1 start = 1'b0;
  endtask
  task automatic wait_done(output int edge_n, output logic [31:0] h, output logic [31:0] l, output logic z);
    edge_n = -1;
    h = 'x;
    l = 'x;
    z = 1'bx;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (done) begin
        edge_n = n - 1;
        h = hi;
        l = lo;
        z = div_zero;
        break;
      end
    end
  endtask
  task automatic mt_write(input logic sel, input logic [31:0] d);
    @(negedge clk);
    hilo_wr = 1'b1;
    wr_sel = sel;
    wr_data = d;
    @(posedge clk);
    #1 hilo_wr = 1'b0;
    if (sel) mhi = d;
    else mlo = d;
  endtask
  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks += 4;
    if (hi !== 32'd0) begin failures++; $display("FAIL reset_hi got=%h exp=0", hi); end
    if (lo !== 32'd0) begin failures++; $display("FAIL reset_lo got=%h exp=0", lo); end
    if ({busy, stall} !== 2'b00) begin failures++; $display("FAIL reset_busy_stall got=%b exp=00", {busy, stall}); end
    if ({done, div_zero} !== 2'b00) begin failures++; $display("FAIL reset_done got=%b exp=00", {done, div_zero}); end
    rst_n = 1'b1;
  endtask
  task automatic test_mult();
    logic [1:0]  to[5] = '{2'd1, 2'd0, 2'd0, 2'd1, 2'd0};
    logic [31:0] ta[5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'h8000_0000, 32'h0, 32'h7FFF_FFFF};
    logic [31:0] tb[5] = '{32'd2, 32'd7, 32'h8000_0000, 32'h1234_5678, 32'hFFFF_FFFF};
    exp_t e;
    int en;
    logic [31:0] h, l;
    logic z;
    for (int i = 0; i < 8; i++) begin
      if (i < 5) start_op(to[i], ta[i], tb[i]);
      else start_op(2'($urandom_range(0, 1)), $urandom, $urandom);
      wait_done(en, h, l, z);
      e = sb.pop_front();
      checks += 5;
      if (en !== 33) begin failures++; $display("FAIL mult_latency[%0d] got=%0d exp=33", i, en); end
      if (h !== e.hi) begin failures++; $display("FAIL mult_hi[%0d] got=%h exp=%h", i, h, e.hi); end
      if (l !== e.lo) begin failures++; $display("FAIL mult_lo[%0d] got=%h exp=%h", i, l, e.lo); end
      if (z !== 1'b0) begin failures++; $display("FAIL mult_divzero[%0d] got=%b exp=0", i, z); end
      @(negedge clk);
      if (done !== 1'b0) begin failures++; $display("FAIL mult_done_pulse[%0d] got=%b exp=0", i, done); end
    end
  endtask
  task automatic test_div();
    logic [1:0]  to[6] = '{2'd2, 2'd2, 2'd3, 2'd2, 2'd2, 2'd3};
    logic [31:0] ta[6] = '{32'hFFFF_FFF9, 32'h8000_0000, 32'hFFFF_FFFF, 32'd100, 32'hFFFF_FF9C, 32'd5};
    logic [31:0] tb[6] = '{32'd2, 32'hFFFF_FFFF, 32'd10, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFFF};
    exp_t e;
    int en;
    logic [31:0] h, l;
    logic z;
    for (int i = 0; i < 9; i++) begin
      if (i < 6) start_op(to[i], ta[i], tb[i]);
      else start_op(2'($urandom_range(2, 3)), $urandom, $urandom_range(1, 32'h7FFF_FFFF) ^ ($urandom_range(0, 1) << 31));
      wait_done(en, h, l, z);
      e = sb.pop_front();
      checks += 4;
      if (en !== 33) begin failures++; $display("FAIL div_latency[%0d] got=%0d exp=33", i, en); end
      if (h !== e.hi) begin failures++; $display("FAIL div_hi[%0d] got=%h exp=%h", i, h, e.hi); end
      if (l !== e.lo) begin failures++; $display("FAIL div_lo[%0d] got=%h exp=%h", i, l, e.lo); end
      if (z !== 1'b0) begin failures++; $display("FAIL div_divzero[%0d] got=%b exp=0", i, z); end
    end
  endtask
  task automatic test_div_zero();
    exp_t e;
    int en;
    logic [31:0] h, l;
    logic z;
    mt_write(1'b1, 32'h1234);
    mt_write(1'b0, 32'h5678);
    checks += 2;
    if (hi !== 32'h1234) begin failures++; $display("FAIL mthi got=%h exp=00001234", hi); end
    if (lo !== 32'h5678) begin failures++; $display("FAIL mtlo got=%h exp=00005678", lo); end
    start_op(2'd3, 32'hABCD, 32'd0);
    wait_done(en, h, l, z);
    e = sb.pop_front();
    checks += 5;
    if (en !== 0) begin failures++; $display("FAIL dz_latency got=%0d exp=0", en); end
    if (z !== e.dz) begin failures++; $display("FAIL dz_flag got=%b exp=%b", z, e.dz); end
    if (h !== e.hi) begin failures++; $display("FAIL dz_hi got=%h exp=%h", h, e.hi); end
    if (l !== e.lo) begin failures++; $display("FAIL dz_lo got=%h exp=%h", l, e.lo); end
    if (busy !== 1'b0) begin failures++; $display("FAIL dz_busy got=%b exp=0", busy); end
    @(negedge clk);
    checks++;
    if ({done, div_zero} !== 2'b00) begin failures++; $display("FAIL dz_pulse got=%b exp=00", {done, div_zero}); end
  endtask
  task automatic test_stall();
    exp_t e;
    int en, busy_cyc;
    logic [31:0] h, l, h0;
    hilo_rd = 1'b1;
    start_op(2'd1, 32'hFFFF_FFFF, 32'd3);
    busy_cyc = 0;
    en = -1;
    h0 = hi;
    for (int n = 1; n <= 40 && en < 0; n++) begin
      @(negedge clk);
      if (busy) begin
        busy_cyc++;
        checks++;
        if (stall !== 1'b1) begin failures++; $display("FAIL stall_busy[%0d] got=%b exp=1", n, stall); end
      end
      if (done) begin
        en = n - 1;
        h = hi;
        l = lo;
      end
      if (n == 10) begin op = 2'd0; a = 32'd7; b = 32'd9; start = 1'b1; end
      if (n == 11) start = 1'b0;
      if (n == 15) begin h0 = hi; hilo_wr = 1'b1; wr_sel = 1'b1; wr_data = 32'hDEAD_BEEF; end
      if (n == 16) begin
        hilo_wr = 1'b0;
        checks++;
        if (hi !== h0) begin failures++; $display("FAIL busy_write got=%h exp=%h", hi, h0); end
      end
    end
    e = sb.pop_front();
    checks += 5;
    if (busy_cyc !== 33) begin failures++; $display("FAIL busy_cycles got=%0d exp=33", busy_cyc); end
    if (en !== 33) begin failures++; $display("FAIL stall_latency got=%0d exp=33", en); end
    if (h !== e.hi) begin failures++; $display("FAIL stall_hi got=%h exp=%h", h, e.hi); end
    if (l !== e.lo) begin failures++; $display("FAIL stall_lo got=%h exp=%h", l, e.lo); end
    if (stall !== 1'b0) begin failures++; $display("FAIL stall_idle got=%b exp=0", stall); end
  endtask
  task automatic test_abort();
    exp_t e;
    int en;
    logic [31:0] h, l;
    logic z;
    start_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks += 4;
    if (hi !== 32'd0) begin failures++; $display("FAIL abort_hi got=%h exp=0", hi); end
    if (lo !== 32'd0) begin failures++; $display("FAIL abort_lo got=%h exp=0", lo); end
    if ({busy, stall} !== 2'b00) begin failures++; $display("FAIL abort_busy_stall got=%b exp=00", {busy, stall}); end
    if ({done, div_zero} !== 2'b00) begin failures++; $display("FAIL abort_done got=%b exp=00", {done, div_zero}); end
    void'(sb.pop_back());
    mhi = '0;
    mlo = '0;
    hilo_rd = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    start_op(2'd1, 32'd6, 32'd7);
    wait_done(en, h, l, z);
    e = sb.pop_front();
    checks += 3;
    if (en !== 33) begin failures++; $display("FAIL post_reset_latency got=%0d exp=33", en); end
    if (l !== e.lo) begin failures++; $display("FAIL post_reset_lo got=%h exp=%h", l, e.lo); end
    if (h !== e.hi) begin failures++; $display("FAIL post_reset_hi got=%h exp=%h", h, e.hi); end
  endtask
  task automatic test_back_to_back();
    exp_t e;
    int en;
    logic [31:0] h, l;
    logic z;
    @(negedge clk);
    op = 2'd0;
    a = 32'hFFFF_FF00;
    b = 32'd300;
    start = 1'b1;
    push_exp(2'd0, 32'hFFFF_FF00, 32'd300);
    @(posedge clk);
    #1;
    op = 2'd2;
    a = 32'd1000;
    b = 32'hFFFF_FFFD;
    push_exp(2'd2, 32'd1000, 32'hFFFF_FFFD);
    wait_done(en, h, l, z);
    e = sb.pop_front();
    checks += 3;
    if (en !== 33) begin failures++; $display("FAIL b2b_first_latency got=%0d exp=33", en); end
    if (h !== e.hi) begin failures++; $display("FAIL b2b_first_hi got=%h exp=%h", h, e.hi); end
    if (l !== e.lo) begin failures++; $display("FAIL b2b_first_lo got=%h exp=%h", l, e.lo); end
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(en, h, l, z);
    e = sb.pop_front();
    checks += 3;
    if (en !== 33) begin failures++; $display("FAIL b2b_second_latency got=%0d exp=33", en); end
    if (h !== e.hi) begin failures++; $display("FAIL b2b_second_hi got=%h exp=%h", h, e.hi); end
    if (l !== e.lo) begin failures++; $display("FAIL b2b_second_lo got=%h exp=%h", l, e.lo); end
  endtask
  initial begin
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_stall();
    test_abort();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
